// File: rtl/matmul_sequencer_if.sv
// Instruction handshake plus buffer, array and accumulator control bundle for matmul_sequencer.
// The master drives instructions in; the slave (the sequencer) drives every strobe and status line.
interface matmul_sequencer_if;
    logic        instr_valid;
    logic [63:0] instr;
    logic        instr_ready;
    logic        inp_buf_we;
    logic [14:0] inp_buf_addr;
    logic [31:0] inp_buf_data;
    logic        wt_buf_we;
    logic [14:0] wt_buf_addr;
    logic [31:0] wt_buf_data;
    logic        array_en;
    logic [7:0]  feed_idx;
    logic        acc_reset;
    logic        acc_store;
    logic [3:0]  acc_op_addr;
    logic        op_buf_rd_en;
    logic [3:0]  op_buf_rd_addr;
    logic        out_valid;
    logic        busy;
    logic        err_illegal;

    modport master (
        output instr_valid, instr,
        input  instr_ready, inp_buf_we, inp_buf_addr, inp_buf_data,
               wt_buf_we, wt_buf_addr, wt_buf_data, array_en, feed_idx,
               acc_reset, acc_store, acc_op_addr, op_buf_rd_en, op_buf_rd_addr,
               out_valid, busy, err_illegal
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, inp_buf_we, inp_buf_addr, inp_buf_data,
               wt_buf_we, wt_buf_addr, wt_buf_data, array_en, feed_idx,
               acc_reset, acc_store, acc_op_addr, op_buf_rd_en, op_buf_rd_addr,
               out_valid, busy, err_illegal
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Decodes 64-bit instructions into buffer writes, systolic compute sequences,
// accumulator strobes and output-buffer reads; one compute or read in flight at a time.
module matmul_sequencer #(
    parameter int ARR_SIZE  = 4,
    parameter int BUF_DEPTH = 32768,
    parameter int OPB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    matmul_sequencer_if.slave bus
);
    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_LOAD_INP = 4'd1;
    localparam logic [3:0] OP_LOAD_WT  = 4'd2;
    localparam logic [3:0] OP_COMPUTE  = 4'd3;
    localparam logic [3:0] OP_READ_OUT = 4'd4;
    localparam logic [3:0] OP_CLR_ACC  = 4'd5;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COMPUTE = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;

    localparam logic [7:0] FEED_LAST = 8'(3 * ARR_SIZE - 3);

    function automatic logic addr_ok(input logic [14:0] a, input int unsigned depth);
        return {17'd0, a} < depth;
    endfunction

    logic [2:0]  state_q;
    logic [3:0]  dest_q;
    logic        ready_q;
    logic        inp_we_q;
    logic [14:0] inp_addr_q;
    logic [31:0] inp_data_q;
    logic        wt_we_q;
    logic [14:0] wt_addr_q;
    logic [31:0] wt_data_q;
    logic        array_en_q;
    logic [7:0]  feed_idx_q;
    logic        acc_reset_q;
    logic        acc_store_q;
    logic [3:0]  acc_op_addr_q;
    logic        rd_en_q;
    logic [3:0]  rd_addr_q;
    logic        out_valid_q;
    logic        busy_q;
    logic        err_q;

    // Stage p0: field extraction and decode of the accepted instruction
    logic        accept_p0;
    logic [3:0]  op_p0;
    logic [14:0] addr_p0;
    logic        keep_p0;
    logic [31:0] data_p0;
    logic        unused_rsvd_p0;
    logic        ld_inp_p0;
    logic        ld_wt_p0;
    logic        clr_p0;
    logic        comp_p0;
    logic        rd_p0;
    logic        illegal_p0;

    assign accept_p0      = bus.instr_valid & ready_q;
    assign op_p0          = bus.instr[63:60];
    assign addr_p0        = bus.instr[59:45];
    assign keep_p0        = bus.instr[32];
    assign data_p0        = bus.instr[31:0];
    assign unused_rsvd_p0 = ^bus.instr[44:33];

    always_comb begin
        ld_inp_p0  = 1'b0;
        ld_wt_p0   = 1'b0;
        clr_p0     = 1'b0;
        comp_p0    = 1'b0;
        rd_p0      = 1'b0;
        illegal_p0 = 1'b0;
        if (accept_p0) begin
            case (op_p0)
                OP_NOP: ;
                OP_LOAD_INP: begin
                    if (addr_ok(addr_p0, BUF_DEPTH)) ld_inp_p0 = 1'b1;
                    else                             illegal_p0 = 1'b1;
                end
                OP_LOAD_WT: begin
                    if (addr_ok(addr_p0, BUF_DEPTH)) ld_wt_p0 = 1'b1;
                    else                             illegal_p0 = 1'b1;
                end
                OP_COMPUTE: begin
                    if (addr_ok(addr_p0, OPB_DEPTH)) comp_p0 = 1'b1;
                    else                             illegal_p0 = 1'b1;
                end
                OP_READ_OUT: begin
                    if (addr_ok(addr_p0, OPB_DEPTH)) rd_p0 = 1'b1;
                    else                             illegal_p0 = 1'b1;
                end
                OP_CLR_ACC: clr_p0 = 1'b1;
                default:    illegal_p0 = 1'b1;
            endcase
        end
    end

    // Stage p1: registered sequencing state and every output strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            dest_q        <= 4'd0;
            ready_q       <= 1'b0;
            inp_we_q      <= 1'b0;
            inp_addr_q    <= 15'd0;
            inp_data_q    <= 32'd0;
            wt_we_q       <= 1'b0;
            wt_addr_q     <= 15'd0;
            wt_data_q     <= 32'd0;
            array_en_q    <= 1'b0;
            feed_idx_q    <= 8'd0;
            acc_reset_q   <= 1'b0;
            acc_store_q   <= 1'b0;
            acc_op_addr_q <= 4'd0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= 4'd0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            inp_we_q    <= ld_inp_p0;
            wt_we_q     <= ld_wt_p0;
            acc_reset_q <= clr_p0 | (comp_p0 & ~keep_p0);
            acc_store_q <= 1'b0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            if (ld_inp_p0) begin
                inp_addr_q <= addr_p0;
                inp_data_q <= data_p0;
            end
            if (ld_wt_p0) begin
                wt_addr_q <= addr_p0;
                wt_data_q <= data_p0;
            end
            if (illegal_p0) err_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (comp_p0) begin
                        state_q    <= S_COMPUTE;
                        array_en_q <= 1'b1;
                        feed_idx_q <= 8'd0;
                        dest_q     <= addr_p0[3:0];
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end else if (rd_p0) begin
                        state_q   <= S_RD_REQ;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= addr_p0[3:0];
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (feed_idx_q == FEED_LAST) begin
                        state_q       <= S_DRAIN;
                        array_en_q    <= 1'b0;
                        feed_idx_q    <= 8'd0;
                        acc_store_q   <= 1'b1;
                        acc_op_addr_q <= dest_q;
                    end else begin
                        feed_idx_q <= feed_idx_q + 8'd1;
                    end
                end
                S_DRAIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                S_RD_REQ: begin
                    state_q     <= S_RD_WAIT;
                    out_valid_q <= 1'b1;
                end
                S_RD_WAIT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    array_en_q <= 1'b0;
                    feed_idx_q <= 8'd0;
                    busy_q     <= 1'b0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_ready    = ready_q;
    assign bus.inp_buf_we     = inp_we_q;
    assign bus.inp_buf_addr   = inp_addr_q;
    assign bus.inp_buf_data   = inp_data_q;
    assign bus.wt_buf_we      = wt_we_q;
    assign bus.wt_buf_addr    = wt_addr_q;
    assign bus.wt_buf_data    = wt_data_q;
    assign bus.array_en       = array_en_q;
    assign bus.feed_idx       = feed_idx_q;
    assign bus.acc_reset      = acc_reset_q;
    assign bus.acc_store      = acc_store_q;
    assign bus.acc_op_addr    = acc_op_addr_q;
    assign bus.op_buf_rd_en   = rd_en_q;
    assign bus.op_buf_rd_addr = rd_addr_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.busy           = busy_q;
    assign bus.err_illegal    = err_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: directed table, corner-case sequences and random traffic
// checked every cycle against a time-indexed schedule of expected output events.
module tb_matmul_sequencer;
    localparam int ARR   = 4;
    localparam int BUFD  = 1024;
    localparam int OPBD  = 16;
    localparam int CLEN  = 3 * ARR - 2;
    localparam int NCYC  = 16384;
    localparam int NEVER = 32'h7fffffff;

    typedef struct packed {
        logic        inp_we;
        logic [14:0] inp_addr;
        logic [31:0] inp_data;
        logic        wt_we;
        logic [14:0] wt_addr;
        logic [31:0] wt_data;
        logic        array_en;
        logic [7:0]  feed;
        logic        acc_reset;
        logic        acc_store;
        logic [3:0]  acc_addr;
        logic        rd_en;
        logic [3:0]  rd_addr;
        logic        out_valid;
        logic        busy;
    } exp_t;

    typedef struct {
        logic [63:0] ins;
        logic        inp_we;
        logic        wt_we;
        logic        acc_reset;
        logic        err;
        logic        busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   ready_from = NEVER;
    int   err_from = NEVER;
    exp_t sched [NCYC];
    vec_t tbl [8];

    matmul_sequencer_if bus ();

    matmul_sequencer #(.ARR_SIZE(ARR), .BUF_DEPTH(BUFD), .OPB_DEPTH(OPBD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [14:0] a,
                                       input logic keep, input logic [31:0] d);
        return {op, a, 12'h000, keep, d};
    endfunction

    function automatic logic [127:0] all_outs();
        return {bus.instr_ready, bus.inp_buf_we, bus.inp_buf_addr, bus.inp_buf_data,
                bus.wt_buf_we, bus.wt_buf_addr, bus.wt_buf_data, bus.array_en,
                bus.feed_idx, bus.acc_reset, bus.acc_store, bus.acc_op_addr,
                bus.op_buf_rd_en, bus.op_buf_rd_addr, bus.out_valid, bus.busy,
                bus.err_illegal};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] ins);
        bus.instr_valid = v;
        bus.instr       = ins;
    endtask

    // Reference model: one accepted instruction expands into its full timeline of output events.
    task automatic schedule(input int e, input logic [63:0] ins);
        logic [3:0]  op;
        logic [14:0] a;
        logic        bad;
        op  = ins[63:60];
        a   = ins[59:45];
        bad = 1'b0;
        case (op)
            4'd0: ;
            4'd1: if (a < BUFD) begin
                sched[e].inp_we = 1'b1; sched[e].inp_addr = a; sched[e].inp_data = ins[31:0];
            end else bad = 1'b1;
            4'd2: if (a < BUFD) begin
                sched[e].wt_we = 1'b1; sched[e].wt_addr = a; sched[e].wt_data = ins[31:0];
            end else bad = 1'b1;
            4'd3: if (a < OPBD) begin
                for (int i = 0; i < CLEN; i++) begin
                    sched[e+i].array_en = 1'b1;
                    sched[e+i].feed     = 8'(i);
                    sched[e+i].busy     = 1'b1;
                end
                sched[e].acc_reset       = ~ins[32];
                sched[e+CLEN].acc_store  = 1'b1;
                sched[e+CLEN].acc_addr   = a[3:0];
                sched[e+CLEN].busy       = 1'b1;
                ready_from               = e + CLEN + 1;
            end else bad = 1'b1;
            4'd4: if (a < OPBD) begin
                sched[e].rd_en       = 1'b1;
                sched[e].rd_addr     = a[3:0];
                sched[e].busy        = 1'b1;
                sched[e+1].out_valid = 1'b1;
                sched[e+1].busy      = 1'b1;
                ready_from           = e + 2;
            end else bad = 1'b1;
            4'd5: sched[e].acc_reset = 1'b1;
            default: bad = 1'b1;
        endcase
        if (bad && err_from == NEVER) err_from = e;
    endtask

    task automatic check_outputs(input int k);
        exp_t x;
        if (!rst_n) begin
            chk("reset_outputs", all_outs(), 128'd0);
            return;
        end
        x = sched[k];
        chk("instr_ready", bus.instr_ready, k >= ready_from);
        chk("err_illegal", bus.err_illegal, k >= err_from);
        chk("busy", bus.busy, x.busy);
        chk("inp_buf_we", bus.inp_buf_we, x.inp_we);
        if (x.inp_we) chk("inp_buf_addr_data", {bus.inp_buf_addr, bus.inp_buf_data}, {x.inp_addr, x.inp_data});
        chk("wt_buf_we", bus.wt_buf_we, x.wt_we);
        if (x.wt_we) chk("wt_buf_addr_data", {bus.wt_buf_addr, bus.wt_buf_data}, {x.wt_addr, x.wt_data});
        chk("array_en", bus.array_en, x.array_en);
        chk("feed_idx", bus.feed_idx, x.feed);
        chk("acc_reset", bus.acc_reset, x.acc_reset);
        chk("acc_store", bus.acc_store, x.acc_store);
        if (x.acc_store) chk("acc_op_addr", bus.acc_op_addr, x.acc_addr);
        chk("op_buf_rd_en", bus.op_buf_rd_en, x.rd_en);
        if (x.rd_en) chk("op_buf_rd_addr", bus.op_buf_rd_addr, x.rd_addr);
        chk("out_valid", bus.out_valid, x.out_valid);
    endtask

    task automatic tick(output bit acc);
        acc = rst_n && bus.instr_valid && (cyc >= ready_from);
        @(posedge clk);
        cyc++;
        if (acc) schedule(cyc, bus.instr);
        #1;
        check_outputs(cyc);
    endtask

    task automatic step();
        bit a;
        tick(a);
    endtask

    task automatic send(input logic [63:0] ins, input bit noisy);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            if (cyc >= ready_from) begin
                if (noisy && $urandom_range(0, 3) == 0) drive(1'b0, {$urandom, $urandom});
                else                                    drive(1'b1, ins);
            end else if (noisy) begin
                drive(1'($urandom_range(0, 1)), {$urandom, $urandom});
            end else begin
                drive(1'b1, ins);
            end
            tick(done);
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout cycle %0d: got no accept, expected accept within 64 cycles", cyc);
        end
        drive(1'b0, 64'd0);
    endtask

    task automatic apply_reset(input int hold);
        rst_n      = 1'b0;
        ready_from = NEVER;
        err_from   = NEVER;
        for (int i = cyc + 1; i <= cyc + CLEN + 4 && i < NCYC; i++) sched[i] = '0;
        #1;
        chk("async_reset_outputs", all_outs(), 128'd0);
        repeat (hold) step();
        rst_n      = 1'b1;
        ready_from = cyc + 1;
    endtask

    function automatic logic [63:0] rand_instr();
        int          p;
        logic [3:0]  op;
        logic [14:0] a;
        p = $urandom_range(0, 99);
        if      (p < 25) op = 4'd1;
        else if (p < 45) op = 4'd2;
        else if (p < 60) op = 4'd3;
        else if (p < 75) op = 4'd4;
        else if (p < 85) op = 4'd5;
        else if (p < 92) op = 4'd0;
        else             op = 4'($urandom_range(6, 15));
        if ($urandom_range(0, 15) == 0) a = 15'($urandom);
        else if (op == 4'd3 || op == 4'd4) a = 15'($urandom_range(0, OPBD - 1));
        else a = 15'($urandom_range(0, BUFD - 1));
        return {op, a, 12'($urandom), 1'($urandom), 32'($urandom)};
    endfunction

    initial begin
        tbl[0] = '{mk(4'h1, 15'h0005, 1'b0, 32'hDEADBEEF), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{mk(4'h2, 15'h03FF, 1'b0, 32'h12345678), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{mk(4'h0, 15'h0011, 1'b1, 32'hFFFFFFFF), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{mk(4'h5, 15'h0000, 1'b0, 32'h00000000), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{mk(4'hF, 15'h0001, 1'b0, 32'hA5A5A5A5), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{mk(4'h1, 15'h7FFF, 1'b0, 32'h0BADF00D), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{mk(4'h3, 15'h0010, 1'b0, 32'h00000000), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{mk(4'h2, 15'h0007, 1'b0, 32'hCAFEF00D), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < NCYC; i++) sched[i] = '0;
        drive(1'b0, 64'd0);

        repeat (3) step();
        rst_n      = 1'b1;
        ready_from = cyc + 1;
        step();

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].ins, 1'b0);
            chk("tbl_inp_we", bus.inp_buf_we, tbl[i].inp_we);
            if (tbl[i].inp_we)
                chk("tbl_inp_addr_data", {bus.inp_buf_addr, bus.inp_buf_data}, {tbl[i].ins[59:45], tbl[i].ins[31:0]});
            chk("tbl_wt_we", bus.wt_buf_we, tbl[i].wt_we);
            if (tbl[i].wt_we)
                chk("tbl_wt_addr_data", {bus.wt_buf_addr, bus.wt_buf_data}, {tbl[i].ins[59:45], tbl[i].ins[31:0]});
            chk("tbl_acc_reset", bus.acc_reset, tbl[i].acc_reset);
            chk("tbl_err_illegal", bus.err_illegal, tbl[i].err);
            chk("tbl_busy", bus.busy, tbl[i].busy);
            step();
        end

        apply_reset(2);
        step();
        drive(1'b1, mk(4'h2, 15'd1, 1'b0, 32'h11111111)); step();
        drive(1'b1, mk(4'h2, 15'd2, 1'b0, 32'h22222222)); step();
        drive(1'b1, mk(4'h1, 15'd3, 1'b0, 32'h33333333)); step();
        drive(1'b0, 64'd0); step();

        send(mk(4'h3, 15'd3, 1'b0, 32'd0), 1'b0);
        chk("cmp_start", {bus.array_en, bus.acc_reset, bus.feed_idx}, {1'b1, 1'b1, 8'd0});
        for (int i = 1; i < CLEN; i++) begin
            step();
            chk("cmp_feed_idx", {bus.array_en, bus.feed_idx}, {1'b1, 8'(i)});
        end
        step();
        chk("cmp_drain", {bus.array_en, bus.acc_store, bus.acc_op_addr}, {1'b0, 1'b1, 4'd3});
        step();
        chk("cmp_ready_back", {bus.instr_ready, bus.busy, bus.acc_store}, {1'b1, 1'b0, 1'b0});

        send(mk(4'h3, 15'd3, 1'b1, 32'd0), 1'b0);
        chk("keep_no_acc_reset", {bus.array_en, bus.acc_reset}, {1'b1, 1'b0});
        send(mk(4'h4, 15'd3, 1'b0, 32'd0), 1'b0);
        chk("rd_req", {bus.op_buf_rd_en, bus.op_buf_rd_addr, bus.out_valid}, {1'b1, 4'd3, 1'b0});
        step();
        chk("rd_wait", {bus.op_buf_rd_en, bus.out_valid}, {1'b0, 1'b1});
        step();
        chk("rd_done", {bus.out_valid, bus.instr_ready}, {1'b0, 1'b1});

        send(mk(4'h3, 15'd9, 1'b0, 32'd0), 1'b0);
        repeat (4) step();
        chk("pre_reset_feed", bus.feed_idx, 8'd4);
        apply_reset(2);
        repeat (CLEN + 2) step();
        send(mk(4'h3, 15'd6, 1'b0, 32'd0), 1'b0);
        repeat (CLEN + 2) step();

        apply_reset(1);
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(0, 11)) step();
                apply_reset($urandom_range(1, 3));
            end
            send(rand_instr(), 1'b1);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) step();
        end
        repeat (CLEN + 3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Sits between the instruction buffer and the systolic datapath. Accepts 64-bit instructions over a valid/ready handshake and decodes them into weight/input buffer writes, systolic compute sequences, accumulator reset/store strobes and output-buffer reads. It is the single point of sequencing for the array: only one compute or read operation is in flight at a time.

Parameters:
ARR_SIZE, 4, systolic array dimension; compute phase lasts 3*ARR_SIZE-2 cycles.
BUF_DEPTH, 32768, entries in the input and weight buffers; load address must be < BUF_DEPTH.
OPB_DEPTH, 16, output-buffer entries; destination and read address must be < OPB_DEPTH.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction buffer has an instruction
instr  input  64  [63:60] opcode, [59:45] addr, [44:33] reserved, [32] acc_keep, [31:0] data
instr_ready  output  1  sequencer accepts instr this cycle
inp_buf_we  output  1  input-buffer write strobe
inp_buf_addr  output  15  input-buffer write address
inp_buf_data  output  32  input-buffer write data
wt_buf_we  output  1  weight-buffer write strobe
wt_buf_addr  output  15  weight-buffer write address
wt_buf_data  output  32  weight-buffer write data
array_en  output  1  systolic array / buffer feed enable
feed_idx  output  8  current compute step, 0..3*ARR_SIZE-3
acc_reset  output  1  clear accumulator, one-cycle pulse
acc_store  output  1  accumulator writes result to output buffer, one-cycle pulse
acc_op_addr  output  4  output-buffer destination for acc_store
op_buf_rd_en  output  1  output-buffer read strobe
op_buf_rd_addr  output  4  output-buffer read address
out_valid  output  1  accelerator_output is valid this cycle
busy  output  1  state != IDLE
err_illegal  output  1  sticky: illegal opcode or out-of-range address seen

Behaviour:
- All outputs registered. Reset (async, rst_n=0): state IDLE, every output 0, including instr_ready. instr_ready rises on the first clk edge after rst_n deasserts.
- Accept = instr_valid & instr_ready. instr_ready = 1 only in IDLE (registered, so it is low in the cycle after a COMPUTE/READ accept).
- Opcodes: 0 NOP, 1 LOAD_INP, 2 LOAD_WT, 3 COMPUTE, 4 READ_OUT, 5 CLR_ACC; 6..15 illegal.
- NOP: no effect; stays IDLE.
- LOAD_INP/LOAD_WT: on accept cycle T, the matching *_we=1 at T+1 with addr/data captured from instr. Stays IDLE, so back-to-back loads run at 1/cycle. *_we is low in any cycle with no load accepted.
- CLR_ACC: acc_reset=1 at T+1 for one cycle; stays IDLE.
- COMPUTE: dest = addr[3:0]. At T+1: state COMPUTE, array_en=1, feed_idx=0, and acc_reset=1 for this cycle only if acc_keep=0. feed_idx increments each cycle. After feed_idx reaches 3*ARR_SIZE-3 (10 cycles for ARR_SIZE=4), state goes to DRAIN: array_en=0, acc_store=1, acc_op_addr=dest for one cycle, then IDLE. The first accept after a compute is possible at T+2+(3*ARR_SIZE-2).
- READ_OUT: at T+1 state RD_REQ: op_buf_rd_en=1, op_buf_rd_addr=addr[3:0]. At T+2 state RD_WAIT: out_valid=1 (1-cycle output-buffer latency). At T+3 state IDLE.
- Illegal opcode, load addr >= BUF_DEPTH, or COMPUTE/READ addr >= OPB_DEPTH: the instruction is consumed with no side effect, err_illegal is set at T+1 and stays set until reset.
- instr_valid while not ready: the instruction is held by the producer and must not be sampled; instr may change freely while instr_ready=0.
- Reset mid-COMPUTE or mid-READ: the sequence aborts immediately. No acc_store or out_valid is emitted, and the state returns to IDLE.
- acc_op_addr and op_buf_rd_addr hold their last value when their strobe is low. feed_idx returns to 0 outside COMPUTE.

Test Plan:
- Reset then LOAD_INP addr=0x0005 data=0xDEADBEEF -> inp_buf_we=1, inp_buf_addr=5, inp_buf_data=0xDEADBEEF one cycle after accept; wt_buf_we stays 0.
- LOAD_WT, LOAD_WT, LOAD_INP on consecutive cycles -> three consecutive write strobes to the correct buffers; instr_ready stays 1 throughout.
- COMPUTE dest=3 acc_keep=0 (ARR_SIZE=4) -> acc_reset and array_en rise together; array_en stays high 10 cycles with feed_idx 0..9; then acc_store=1 with acc_op_addr=3; instr_ready is back to 1 after 12 cycles.
- COMPUTE acc_keep=1 with instr_valid held high on a following READ_OUT addr=3 -> no acc_reset; READ is accepted only after DRAIN; op_buf_rd_en at +1, out_valid at +2, each one cycle.
- Opcode 0xF, then LOAD_INP addr=0x7FFF with BUF_DEPTH=1024 -> no strobes; err_illegal=1 and stays 1 through subsequent legal instructions.
- rst_n pulled low at feed_idx=4 of a COMPUTE -> all outputs 0 immediately; no acc_store afterwards; a new COMPUTE accepted after release runs a full 10-cycle sequence.
